pc: RTL and testbench

- 4-bit program counter for the 4-bit CPU.
- Holds the address of the current instruction and drives it to instruction memory.
- On each rising clock edge it does one of two things:
  - increments the address, or
  - takes a PC-relative conditional branch, when a branch-if-equal instruction is present and the ALU equality flag is set.

---
 rtl/pc.sv | 87 ++++++++
 tb/tb_pc.sv | 110 +++++++++++
 2 files changed

// File: rtl/pc.sv
// -----------------------------------------------------------------------------
// pc : program counter for the 4-bit CPU
//
// Holds the address of the current instruction and presents it to instruction
// memory. Every rising clock edge the counter either advances by one or, for a
// taken branch, moves by the sign-extended 4-bit offset in INS[7:4]. All
// arithmetic wraps modulo 2^PC_WIDTH.
//
// Ports
//   clk      in   1          system clock, rising-edge active
//   set_pc   in   1          synchronous active-high reset, forces PC to 0
//   alu_eq   in   1          ALU equality flag, condition for BEQ
//   INS      in   INS_WIDTH  current instruction word
//                            [10:8] opcode, [7:4] signed offset, [3:0] unused
//   PC_CURR  out  PC_WIDTH   current PC, straight from the register
//
// Build option
//   PC_JUMP_EN  when defined, opcode 3'b101 (JMP) is an unconditional relative
//               branch. When undefined, 3'b101 simply increments the PC.
// -----------------------------------------------------------------------------
module pc #(
  parameter int PC_WIDTH  = 4,
  parameter int INS_WIDTH = 11
) (
  input  logic                 clk,
  input  logic                 set_pc,
  input  logic                 alu_eq,
  input  logic [INS_WIDTH-1:0] INS,
  output logic [PC_WIDTH-1:0]  PC_CURR
);

  localparam int OFF_WIDTH = 4;

  typedef enum logic [2:0] {
    OP_BEQ = 3'b100,
    OP_JMP = 3'b101
  } opcode_e;

  logic [2:0]           opcode;
  logic [OFF_WIDTH-1:0] offset;
  logic [PC_WIDTH-1:0]  offset_ext;
  logic                 branch_taken;
  logic [PC_WIDTH-1:0]  pc_d;
  logic [PC_WIDTH-1:0]  pc_q;

  assign opcode = INS[10:8];
  assign offset = INS[7:4];

  // A size cast of a signed operand sign-extends, so this stays correct if
  // PC_WIDTH is ever widened beyond the offset field.
  assign offset_ext = PC_WIDTH'(signed'(offset));

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned; an unassigned path would infer a latch.
    branch_taken = 1'b0;
    pc_d         = pc_q + PC_WIDTH'(1);

    if (opcode == OP_BEQ && alu_eq) begin
      branch_taken = 1'b1;
    end
`ifdef PC_JUMP_EN
    if (opcode == OP_JMP) begin
      branch_taken = 1'b1;
    end
`endif

    // Offset 0 on a taken branch holds the PC, giving a self-loop.
    if (branch_taken) begin
      pc_d = pc_q + offset_ext;
    end
  end

  // Reset is synchronous and outranks any branch presented on the same edge.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every flop samples
    // its inputs from before the edge, independent of statement order.
    if (set_pc) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign PC_CURR = pc_q;

endmodule

// File: tb/tb_pc.sv
// -----------------------------------------------------------------------------
// tb_pc : directed self-checking bench for pc
// Each step drives inputs on the falling edge, lets one rising edge pass, and
// compares PC_CURR 1 ns later against a hand-computed value.
// -----------------------------------------------------------------------------
module tb_pc;

  localparam logic [10:0] INS_NOP    = 11'b011_0000_0000;
  localparam logic [10:0] INS_BEQ_P7 = 11'b100_0111_0000;
  localparam logic [10:0] INS_BEQ_M8 = 11'b100_1000_0000;
  localparam logic [10:0] INS_BEQ_0  = 11'b100_0000_0000;
  localparam logic [10:0] INS_BEQ_P1 = 11'b100_0001_0000;
  localparam logic [10:0] INS_JMP_P5 = 11'b101_0101_0000;
  localparam logic [10:0] INS_OP6_P5 = 11'b110_0101_0000;

  logic        clk;
  logic        set_pc;
  logic        alu_eq;
  logic [10:0] ins;
  logic [3:0]  pc_curr;

  int checks = 0;
  int errors = 0;

  pc #(.PC_WIDTH(4), .INS_WIDTH(11)) dut (
    .clk     (clk),
    .set_pc  (set_pc),
    .alu_eq  (alu_eq),
    .INS     (ins),
    .PC_CURR (pc_curr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (%b) expected %0d", tag, got, got, exp);
    end
  endtask

  task automatic step(input logic rst, input logic [10:0] i, input logic eq);
    @(negedge clk);
    set_pc = rst;
    ins    = i;
    alu_eq = eq;
    @(posedge clk);
    #1;
  endtask

  initial begin
    set_pc = 1'b0;
    alu_eq = 1'b0;
    ins    = INS_NOP;

    // Reset with alu_eq high and a non-branch instruction.
    step(1'b1, INS_NOP, 1'b1);
    check("reset", pc_curr, 4'd0);

    // Count through the full address space and wrap.
    for (int k = 1; k <= 16; k++) begin
      step(1'b0, INS_NOP, 1'b0);
      check($sformatf("count_%0d", k), pc_curr, 4'(k));
    end

    // From 0: BEQ +7 -> 7, BEQ -8 -> 15, BEQ +0 holds twice, BEQ +1 wraps to 0.
    step(1'b0, INS_BEQ_P7, 1'b1);
    check("beq_fwd", pc_curr, 4'd7);
    step(1'b0, INS_BEQ_M8, 1'b1);
    check("beq_neg_wrap", pc_curr, 4'd15);
    step(1'b0, INS_BEQ_0, 1'b1);
    check("beq_hold_1", pc_curr, 4'd15);
    step(1'b0, INS_BEQ_0, 1'b1);
    check("beq_hold_2", pc_curr, 4'd15);
    step(1'b0, INS_BEQ_P1, 1'b1);
    check("beq_pos_wrap", pc_curr, 4'd0);

    // Reach PC=3, then BEQ with alu_eq=0 increments.
    for (int k = 1; k <= 3; k++) begin
      step(1'b0, INS_NOP, 1'b1);
      check($sformatf("to3_%0d", k), pc_curr, 4'(k));
    end
    step(1'b0, INS_BEQ_P7, 1'b0);
    check("beq_not_taken", pc_curr, 4'd4);

    // Reset beats a taken branch on the same edge.
    step(1'b1, INS_BEQ_P7, 1'b1);
    check("reset_priority", pc_curr, 4'd0);

    // Other opcodes never branch, even with alu_eq high.
    step(1'b0, INS_OP6_P5, 1'b1);
    check("op110_incr", pc_curr, 4'd1);
    step(1'b0, INS_NOP, 1'b0);
    check("to2", pc_curr, 4'd2);

    // JMP +5 from 2 with alu_eq low.
    step(1'b0, INS_JMP_P5, 1'b0);
`ifdef PC_JUMP_EN
    check("jmp", pc_curr, 4'd7);
`else
    check("jmp_disabled", pc_curr, 4'd3);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
